branch_target_table: RTL and testbench
======================================

Name: branch_target_table

Overview:
- Parametrised, run-time-programmable successor to the fixed branch-target lookup used by the fetch stage.
- Holds 2**A entries. Each entry is a D-bit target, an absolute/relative mode bit and a valid bit.
- Lookups are registered with 1-cycle latency. Relative entries are resolved against the supplied PC using modulo-2**D arithmetic.
- After reset, a built-in init sequencer clears the table one entry per cycle before the block accepts traffic.

Parameters:
- D, 12, PC/target width in bits.
- A, 6, entry address width; table depth = 2**A.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Ready  output  1  high when the init sweep has finished and the table accepts writes and lookups.
- WrEn  input  1  write request, qualified by Ready.
- WrAddr  input  A  entry to write.
- WrTarget  input  D  absolute target, or two's-complement offset when WrRel=1.
- WrRel  input  1  1 = relative entry, 0 = absolute entry.
- WrAck  output  1  one-cycle pulse, the cycle after an accepted write.
- LkEn  input  1  lookup request, qualified by Ready.
- LkAddr  input  A  entry to look up.
- PC  input  D  current PC, sampled with LkEn; used for relative entries.
- TgtValid  output  1  high for one cycle carrying the lookup result.
- Hit  output  1  entry was valid; meaningful only when TgtValid=1.
- Target  output  D  resolved target; meaningful only when TgtValid=1.

Behaviour:
- States:
  - INIT: entered on Reset.
  - READY: the operating state.
- Reset (any cycle Reset=1):
  - State goes to INIT and the init counter goes to 0.
  - Ready=0, WrAck=0, TgtValid=0, Hit=0, Target=0.
  - Any in-flight lookup result is discarded.
  - Reset dominates every other input.
- INIT:
  - Each cycle clears valid[counter] and increments the counter.
  - When counter = 2**A-1 has been cleared, the next state is READY.
  - Ready rises in the cycle after the final clear, i.e. Ready=1 on the (2**A+1)th cycle after Reset deasserts.
  - WrEn and LkEn are ignored: no WrAck, no TgtValid.
  - Target/mode storage need not be cleared; only the valid bits are.
- Write (READY, WrEn=1):
  - Stores WrTarget and WrRel at WrAddr and sets valid.
  - WrAck=1 on the next cycle.
  - Back-to-back writes are allowed every cycle.
  - A write to the same address overwrites the entry.
- Lookup (READY, LkEn=1 in cycle n):
  - In cycle n+1: TgtValid=1 and Hit=valid[LkAddr].
  - Hit=1 and absolute entry: Target = stored value.
  - Hit=1 and relative entry: Target = (PC + stored) mod 2**D. The sum is truncated to D bits, with no carry-out or overflow flag.
  - Hit=0: Target=0.
  - When LkEn=0, TgtValid=0 next cycle. Hit and Target then hold their last values and are don't-care.
  - Fully pipelined: one lookup per cycle.
- Write and lookup in the same cycle:
  - Both are accepted.
  - Same address: the lookup returns the pre-write contents (read-before-write). The new value is visible from the following cycle's lookup.
- PC and LkAddr are sampled only in the LkEn cycle; later changes do not affect the result.
- No back-pressure exists; consumers must take TgtValid in the cycle it is high.

Test Plan:
- Reset for 1 cycle then release, D=12, A=6:
  - Ready=0 for 64 cycles, then 1.
  - LkEn pulsed during INIT produces no TgtValid.
  - WrEn during INIT produces no WrAck.
- Write addr 1, abs, target 39; next cycle lookup addr 1:
  - WrAck pulses.
  - The lookup cycle is followed by TgtValid=1, Hit=1, Target=39.
- Relative modulo arithmetic: write addr 2 rel 0xFFF (-1).
  - Lookup with PC=0x004 gives Target=0x003.
  - Rewrite addr 2 rel 0xFFB (-5); PC=0x002 gives Target=0xFFD (wrap).
  - Rewrite addr 2 rel 0x014 (+20); PC=0xFF0 gives Target=0x004.
- Lookup unwritten addr 5 gives TgtValid=1, Hit=0, Target=0. Back-to-back lookups of addr 1, 5, 1 on consecutive cycles give results 39/hit, 0/miss, 39/hit on consecutive cycles.
- Same-cycle write of addr 1 abs 20 with lookup of addr 1:
  - The result is 39.
  - The lookup of addr 1 in the next cycle returns 20.
- Reset asserted the cycle after a LkEn following several writes:
  - No TgtValid appears.
  - Ready=0 for 64 cycles.
  - Afterwards, lookups of addr 1 and 2 give Hit=0, Target=0.

Source files
------------

// File: rtl/branch_target_table_if.sv
// Write/lookup bus of the branch target table.
// The master side drives requests, the slave (table) returns acks and results.
interface branch_target_table_if #(
    parameter int D = 12,
    parameter int A = 6
);
    logic         ready;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_target;
    logic         wr_rel;
    logic         wr_ack;
    logic         lk_en;
    logic [A-1:0] lk_addr;
    logic [D-1:0] pc;
    logic         tgt_valid;
    logic         hit;
    logic [D-1:0] target;

    modport master (
        input  ready, wr_ack, tgt_valid, hit, target,
        output wr_en, wr_addr, wr_target, wr_rel, lk_en, lk_addr, pc
    );

    modport slave (
        output ready, wr_ack, tgt_valid, hit, target,
        input  wr_en, wr_addr, wr_target, wr_rel, lk_en, lk_addr, pc
    );
endinterface

// File: rtl/branch_target_table.sv
// Run-time programmable branch target table: 2**A entries, 1-cycle registered
// lookups, relative entries resolved modulo 2**D against the supplied PC.
module branch_target_table #(
    parameter int D = 12,
    parameter int A = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_target_table_if.slave  bus
);
    localparam int DEPTH = 1 << A;

    typedef enum logic [0:0] {INIT, READY} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [A-1:0] init_cnt;
    logic         clr_en;

    logic [D-1:0]     tgt_mem [DEPTH];
    logic [DEPTH-1:0] rel_mem;
    logic [DEPTH-1:0] valid_mem;

    logic wr_acc;
    logic lk_acc;

    logic         entry_vld_p0;
    logic         entry_rel_p0;
    logic [D-1:0] entry_tgt_p0;
    logic [D-1:0] resolved_p0;

    logic         vld_p1;
    logic         ack_p1;
    logic         hit_p1;
    logic [D-1:0] target_p1;

    function automatic logic [D-1:0] resolve(
        input logic         vld,
        input logic         rel,
        input logic [D-1:0] stored,
        input logic [D-1:0] base
    );
        if (!vld)
            return '0;
        if (rel)
            return stored + base;  // D-bit sum, carry discarded
        return stored;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clr_en)
                init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_en    = 1'b0;
        case (state)
            INIT: begin
                clr_en = 1'b1;
                if (init_cnt == '1)
                    state_nxt = READY;
            end
            READY: state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    assign wr_acc = (state == READY) && bus.wr_en && !reset;
    assign lk_acc = (state == READY) && bus.lk_en && !reset;

    // Only the valid bits are swept; payload storage is left as-is.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en)
                valid_mem[init_cnt] <= 1'b0;
            else if (wr_acc)
                valid_mem[bus.wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            tgt_mem[bus.wr_addr] <= bus.wr_target;
            rel_mem[bus.wr_addr] <= bus.wr_rel;
        end
    end

    // Stage p0: read the entry before any same-cycle write lands.
    always_comb begin
        entry_vld_p0 = valid_mem[bus.lk_addr];
        entry_rel_p0 = rel_mem[bus.lk_addr];
        entry_tgt_p0 = tgt_mem[bus.lk_addr];
        resolved_p0  = resolve(entry_vld_p0, entry_rel_p0, entry_tgt_p0, bus.pc);
    end

    // Stage p1: registered result and write acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            ack_p1    <= 1'b0;
            hit_p1    <= 1'b0;
            target_p1 <= '0;
        end else begin
            vld_p1 <= lk_acc;
            ack_p1 <= wr_acc;
            if (lk_acc) begin
                hit_p1    <= entry_vld_p0;
                target_p1 <= resolved_p0;
            end
        end
    end

    // Reset blanks every output in the very cycle it is asserted.
    assign bus.ready     = (state == READY) && !reset;
    assign bus.wr_ack    = ack_p1 && !reset;
    assign bus.tgt_valid = vld_p1 && !reset;
    assign bus.hit       = hit_p1 && !reset;
    assign bus.target    = reset ? '0 : target_p1;
endmodule

// File: tb/tb_branch_target_table.sv
// Bench for branch_target_table: randomized and directed traffic checked every
// cycle against a table-level reference model, plus literal spot checks.
module tb_branch_target_table;
    localparam int D     = 12;
    localparam int A     = 6;
    localparam int DEPTH = 1 << A;
    localparam int MOD   = 1 << D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_target_table_if #(.D(D), .A(A)) bus ();

    branch_target_table #(.D(D), .A(A)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int m_tgt   [DEPTH];
    bit m_rel   [DEPTH];
    bit m_valid [DEPTH];
    int init_left = DEPTH;
    bit e_ready, e_ack, e_tv, e_hit;
    int e_tgt;
    bit chk_en = 1'b0;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: table of entries plus a countdown of init cycles left.
    task automatic model_update();
        int a;
        if (reset) begin
            init_left = DEPTH;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            e_ack = 0; e_tv = 0; e_hit = 0; e_tgt = 0;
        end else if (init_left > 0) begin
            init_left--;
            e_ack = 0; e_tv = 0;
        end else begin
            e_tv = bus.lk_en;
            if (bus.lk_en) begin
                a = int'(bus.lk_addr);
                e_hit = m_valid[a];
                if (!m_valid[a])   e_tgt = 0;
                else if (m_rel[a]) e_tgt = (int'(bus.pc) + m_tgt[a]) % MOD;
                else               e_tgt = m_tgt[a];
            end
            e_ack = bus.wr_en;
            if (bus.wr_en) begin
                a = int'(bus.wr_addr);
                m_tgt[a]   = int'(bus.wr_target);
                m_rel[a]   = bus.wr_rel;
                m_valid[a] = 1'b1;
            end
        end
        e_ready = (init_left == 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(bus.ready), 32'(e_ready && !reset));
            check("wr_ack", 32'(bus.wr_ack), 32'(e_ack && !reset));
            check("tgt_valid", 32'(bus.tgt_valid), 32'(e_tv && !reset));
            if (reset) begin
                check("hit_rst", 32'(bus.hit), 32'd0);
                check("target_rst", 32'(bus.target), 32'd0);
            end else if (e_tv) begin
                check("hit", 32'(bus.hit), 32'(e_hit));
                check("target", 32'(bus.target), 32'(e_tgt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_target = '0; bus.wr_rel = 0;
        bus.lk_en = 0; bus.lk_addr = '0; bus.pc = '0;
    endtask

    task automatic do_write(input int a, input int t, input bit r);
        bus.wr_en = 1; bus.wr_addr = A'(a); bus.wr_target = D'(t); bus.wr_rel = r;
    endtask

    task automatic do_lookup(input int a, input int p);
        bus.lk_en = 1; bus.lk_addr = A'(a); bus.pc = D'(p);
    endtask

    task automatic randomize_inputs(input int max_addr);
        bus.wr_en     = 1'($urandom_range(0, 1));
        bus.wr_addr   = A'($urandom_range(0, max_addr));
        bus.wr_target = D'($urandom);
        bus.wr_rel    = 1'($urandom_range(0, 1));
        bus.lk_en     = 1'($urandom_range(0, 1));
        bus.lk_addr   = A'($urandom_range(0, max_addr));
        bus.pc        = D'($urandom);
    endtask

    task automatic lit_lookup(input string nm, input bit hit, input int tgt);
        check({nm, "_tv"}, 32'(bus.tgt_valid), 32'd1);
        check({nm, "_hit"}, 32'(bus.hit), 32'(hit));
        check({nm, "_tgt"}, 32'(bus.target), 32'(tgt));
    endtask

    task automatic init_sweep(input bit noisy);
        for (int i = 1; i < DEPTH; i++) begin
            if (noisy) randomize_inputs(3); else idle();
            step();
            check("init_ready_low", 32'(bus.ready), 32'd0);
        end
        idle();
        step();
        check("init_ready_high", 32'(bus.ready), 32'd1);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        init_sweep(1'b1);

        do_write(1, 39, 0);
        step();
        check("wr_ack_lit", 32'(bus.wr_ack), 32'd1);
        idle(); do_lookup(1, 'h123);
        step();
        lit_lookup("abs39", 1'b1, 39);

        idle(); do_write(2, 'hFFF, 1); step();
        idle(); do_lookup(2, 'h004); step();
        lit_lookup("rel_m1", 1'b1, 'h003);
        idle(); do_write(2, 'hFFB, 1); step();
        idle(); do_lookup(2, 'h002); step();
        lit_lookup("rel_m5_wrap", 1'b1, 'hFFD);
        idle(); do_write(2, 'h014, 1); step();
        idle(); do_lookup(2, 'hFF0); step();
        lit_lookup("rel_p20_wrap", 1'b1, 'h004);

        idle(); do_lookup(5, 'h777); step();
        lit_lookup("miss5", 1'b0, 0);
        do_lookup(1, 0); step();
        lit_lookup("b2b_1a", 1'b1, 39);
        do_lookup(5, 0); step();
        lit_lookup("b2b_5", 1'b0, 0);
        do_lookup(1, 0); step();
        lit_lookup("b2b_1b", 1'b1, 39);

        idle(); do_write(1, 20, 0); do_lookup(1, 0); step();
        lit_lookup("rbw_old", 1'b1, 39);
        idle(); do_lookup(1, 0); step();
        lit_lookup("rbw_new", 1'b1, 20);

        for (int i = 0; i < 400; i++) begin
            randomize_inputs(7);
            step();
        end

        idle(); do_write(1, 'h0AB, 0); step();
        idle(); do_write(2, 'h00C, 1); step();
        idle(); do_lookup(1, 0);
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b1;
        idle();
        @(negedge clk);
        check("rst_drops_tv", 32'(bus.tgt_valid), 32'd0);
        #1;
        step();
        reset = 1'b0;
        init_sweep(1'b0);
        do_lookup(1, 0); step();
        lit_lookup("post_rst_1", 1'b0, 0);
        do_lookup(2, 'h100); step();
        lit_lookup("post_rst_2", 1'b0, 0);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
